serial_add_ctrl: RTL and testbench

- Bit-serial N-bit adder controller that shares one 1-bit full-adder cell over WIDTH cycles, processing operands LSB first.
- Captures the operands, shifts one bit per cycle through the cell, and holds the carry between cycles in a flop.
- Presents the WIDTH-bit sum and carry-out with a one-cycle done pulse.
- Sits between a request source (bench or sequencer) and the 1-bit adder datapath.

---
 rtl/serial_add_pkg.sv | 19 +
 rtl/full_add_bit.sv | 24 ++
 rtl/serial_add_ctrl.sv | 156 +++++++++++++++
 tb/tb_serial_add_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder controller:
//   - state_e   : controller FSM state encoding (IDLE, RUN, DONE)
//   - WIDTH_MIN : smallest supported operand width
//   - WIDTH_MAX : largest supported operand width
// -----------------------------------------------------------------------------
package serial_add_pkg;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : serial_add_pkg

// File: rtl/full_add_bit.sv
// -----------------------------------------------------------------------------
// full_add_bit
// Combinational 1-bit full adder: {co, sum} = a + b + ci.
// Ports:
//   a, b : operand bits
//   ci   : carry in
//   sum  : sum bit
//   co   : carry out
// -----------------------------------------------------------------------------
module full_add_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign sum      = half_sum ^ ci;
  assign co       = (a & b) | (ci & half_sum);

endmodule : full_add_bit

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial WIDTH-bit adder. One full_add_bit cell is reused over WIDTH
// cycles, LSB first, with the inter-bit carry held in a flop. The result is
// presented with a one-cycle done pulse and held until the next result.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, accepted only while ready=1 and abort=0
//   abort      : synchronous cancel of an operation in RUN
//   a, b, cin  : operands and carry-in, captured on an accepted start
//   ready      : high in IDLE and DONE
//   busy       : high in RUN
//   done       : one-cycle pulse, sum/cout valid
//   sum, cout  : result and final carry
// Supported WIDTH range is serial_add_pkg::WIDTH_MIN..WIDTH_MAX.
// -----------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;     // operand shift registers, consumed LSB first
  logic [WIDTH-1:0] acc_q;        // partial sum, filled from the MSB side
  logic [WIDTH-1:0] sum_q;        // published result, only written on the last bit
  logic             cout_q;
  logic             carry_q;      // carry between successive bit cycles
  logic [CNT_W-1:0] cnt_q;

  logic             cell_sum, cell_co;
  logic             last_bit;
  logic             accept;
  logic             run_step;
  logic [WIDTH-1:0] acc_d;

  // ---------------------------------------------------------------------------
  // Shared 1-bit datapath
  // ---------------------------------------------------------------------------
  full_add_bit u_cell (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .ci  (carry_q),
    .sum (cell_sum),
    .co  (cell_co)
  );

  assign last_bit = (cnt_q == LAST_BIT);
  // abort beats start: a cancelled cycle never starts new work.
  assign accept   = ready && start && !abort;
  assign run_step = (state_q == RUN) && !abort;
  // Right shift with the new bit entering at the MSB; after WIDTH steps the
  // first (LSB) bit has arrived at position 0.
  assign acc_d    = (acc_q >> 1) | {cell_sum, {(WIDTH-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !abort) state_d = RUN;
      RUN: begin
        if (abort)         state_d = IDLE;
        else if (last_bit) state_d = DONE;
      end
      // Back-to-back: a start during DONE goes straight into the next RUN.
      DONE:    state_d = (start && !abort) ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      IDLE:    ready = 1'b1;
      RUN:     busy  = 1'b1;
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter, shift registers and result registers
  // ---------------------------------------------------------------------------
  // NOTE: every register here, including the data shift registers, is reset
  // so the outputs and internal state are defined immediately after rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else if (run_step) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      carry_q <= cell_co;
      acc_q   <= acc_d;
      // Parked at zero on the last bit so the counter never wraps mid-operation.
      cnt_q   <= last_bit ? '0 : cnt_q + CNT_W'(1);
      if (last_bit) begin
        sum_q  <= acc_d;
        cout_q <= cell_co;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Directed-vector bench for serial_add_ctrl at WIDTH=8. Inputs are driven and
// outputs sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, abort, cin;
  logic [W-1:0] a, b;
  logic         ready, busy, done, cout;
  logic [W-1:0] sum;

  int n_cmp = 0;
  int n_err = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted start, then scramble the operand inputs so only the
  // captured copies can produce the right answer.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    start = 1'b1; a = av; b = bv; cin = cv;
    step();
    start = 1'b0; a = 8'hC3; b = 8'h5E; cin = ~cv;
  endtask

  task automatic wait_done(output int edges, output int nbusy);
    edges = 0;
    nbusy = 0;
    while (!done && edges < 40) begin
      if (busy) nbusy++;
      step();
      edges++;
    end
  endtask

  // Full operation from an idle controller, with latency/busy/pulse checks.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic [W-1:0] exp_sum, input logic exp_cout);
    int edges, nbusy;
    start_op(av, bv, cv);
    wait_done(edges, nbusy);
    check({tag, "_latency"}, edges, W);
    check({tag, "_busy_cycles"}, nbusy, W);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, cout, exp_cout);
    check({tag, "_ready_in_done"}, ready, 1);
    step();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_sum_held"}, sum, exp_sum);
  endtask

  initial begin
    int edges, nbusy, extra_done;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cin = 1'b0; a = '0; b = '0;
    #12;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;
    step();

    // 1. basic add
    run_op("t1", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);

    // 2. carry boundaries
    run_op("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // 3. start while busy is ignored: 0x12+0x34+1 = 0x47
    start_op(8'h12, 8'h34, 1'b1);
    step(); step();
    start = 1'b1; a = 8'h11; b = 8'h11;
    step();
    start = 1'b0;
    wait_done(edges, nbusy);
    check("t3_latency", edges, W - 3);
    check("t3_sum", sum, 8'h47);
    check("t3_cout", cout, 0);
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) extra_done++;
    end
    check("t3_no_second_done", extra_done, 0);
    check("t3_idle", ready, 1);

    // 4. back-to-back: 0x20+0x30 then 0x01+0x02 with no idle cycle
    start_op(8'h20, 8'h30, 1'b0);
    wait_done(edges, nbusy);
    check("t4a_sum", sum, 8'h50);
    start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
    step();
    start = 1'b0;
    check("t4_no_bubble", busy, 1);
    wait_done(edges, nbusy);
    check("t4b_latency", edges, W);
    check("t4b_sum", sum, 8'h03);
    check("t4b_cout", cout, 0);
    step();

    // 5. abort in RUN cycle 4 keeps the prior result (0x03, cout 0)
    start_op(8'h0F, 8'h01, 1'b0);
    step(); step(); step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_abort_busy", busy, 0);
    check("t5_abort_ready", ready, 1);
    check("t5_abort_sum", sum, 8'h03);
    check("t5_abort_cout", cout, 0);
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) extra_done++;
      step();
    end
    check("t5_no_done", extra_done, 0);
    start = 1'b1; abort = 1'b1; a = 8'h01; b = 8'h01;
    step();
    start = 1'b0; abort = 1'b0;
    check("t5_abort_wins_busy", busy, 0);
    check("t5_abort_wins_ready", ready, 1);

    // 6. asynchronous reset mid-RUN
    start_op(8'hAA, 8'h55, 1'b0);
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", ready, 1);
    check("t6_rst_done", done, 0);
    check("t6_rst_sum", sum, 0);
    check("t6_rst_cout", cout, 0);
    step();
    rst_n = 1'b1;
    step();
    run_op("t6", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_serial_add_ctrl
